// File: rtl/int_seq_pkg.sv
// rtl/int_seq_pkg.sv - shared types and constants for the interrupt sequencer (INT_SAVE_FLAGS_EN adds the flag push)
package int_seq_pkg;

    localparam int PC_W   = 32;
    localparam int WORD_W = 16;

`ifdef INT_SAVE_FLAGS_EN
    localparam int PUSH_WORDS = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_PUSH_HI,
        S_PUSH_LO,
        S_PUSH_FLG,
        S_RD_HI,
        S_RD_LO,
        S_JUMP
    } int_state_t;
`else
    localparam int PUSH_WORDS = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_PUSH_HI,
        S_PUSH_LO,
        S_RD_HI,
        S_RD_LO,
        S_JUMP
    } int_state_t;
`endif

endpackage

// File: rtl/int_req_latch.sv
// rtl/int_req_latch.sv - interrupt rise detector with a sticky pending flag
module int_req_latch (
    input  logic clk,
    input  logic reset,
    input  logic interrupt_signal,
    input  logic clear,
    output logic rise,
    output logic pending
);

    logic sig_q;
    logic sig_d;
    logic pending_q;
    logic pending_d;

    assign rise    = interrupt_signal & ~sig_q;
    assign pending = pending_q;

    // A rise is remembered until the sequencer starts; clear wins because the
    // starting sequence is the one servicing any same-cycle rise.
    always_comb begin
        sig_d     = interrupt_signal;
        pending_d = clear ? 1'b0 : (pending_q | rise);
    end

    // Edge history and pending flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sig_q     <= sig_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - interrupt entry sequencer: flush, push PC (and flags with INT_SAVE_FLAGS_EN), fetch vector, redirect PC
module interrupt_sequencer
    import int_seq_pkg::*;
#(
    parameter logic [31:0] VEC_ADDR = 32'd0,
    parameter int          FLAG_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              interrupt_signal,
    input  logic              boundary_ok,
    input  logic [PC_W-1:0]   pc_resume,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              fetch_stall,
    output logic              flush_decode,
    output logic              mem_push,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic [PC_W-1:0]   mem_raddr,
    output logic              pc_write,
    output logic [PC_W-1:0]   pc_next,
    output logic              pc_choose_interrupt,
    output logic              busy,
    output logic              int_pending
);

    localparam logic [PC_W-1:0] VEC_ADDR_LO = VEC_ADDR + 32'd1;

    int_state_t        state_q;
    int_state_t        state_d;
    logic [PC_W-1:0]   pc_save_q;
    logic [PC_W-1:0]   pc_save_d;
    logic [WORD_W-1:0] vec_hi_q;
    logic [WORD_W-1:0] vec_hi_d;
    logic              rise;
    logic              pending;
    logic              start;

`ifdef INT_SAVE_FLAGS_EN
    logic [FLAG_W-1:0] flg_save_q;
    logic [FLAG_W-1:0] flg_save_d;
`else
    logic              unused_flags;
    assign unused_flags = ^flags_in;
`endif

    assign start       = (state_q == S_IDLE) && (pending || rise) && boundary_ok;
    assign int_pending = pending;

    int_req_latch u_req_latch (
        .clk              (clk),
        .reset            (reset),
        .interrupt_signal (interrupt_signal),
        .clear            (start),
        .rise             (rise),
        .pending          (pending)
    );

    // State and capture registers; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_save_q  <= '0;
            vec_hi_q   <= '0;
`ifdef INT_SAVE_FLAGS_EN
            flg_save_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_save_q  <= pc_save_d;
            vec_hi_q   <= vec_hi_d;
`ifdef INT_SAVE_FLAGS_EN
            flg_save_q <= flg_save_d;
`endif
        end
    end

    // Next state and captures: fixed walk through the sequence once started.
    always_comb begin
        state_d    = state_q;
        pc_save_d  = pc_save_q;
        vec_hi_d   = vec_hi_q;
`ifdef INT_SAVE_FLAGS_EN
        flg_save_d = flg_save_q;
`endif
        case (state_q)
            S_IDLE:    if (start) state_d = S_FLUSH;
            S_FLUSH: begin
                pc_save_d  = pc_resume;
`ifdef INT_SAVE_FLAGS_EN
                flg_save_d = flags_in;
`endif
                state_d    = S_PUSH_HI;
            end
            S_PUSH_HI: state_d = S_PUSH_LO;
`ifdef INT_SAVE_FLAGS_EN
            S_PUSH_LO:  state_d = S_PUSH_FLG;
            S_PUSH_FLG: state_d = S_RD_HI;
`else
            S_PUSH_LO:  state_d = S_RD_HI;
`endif
            S_RD_HI:   state_d = S_RD_LO;
            S_RD_LO: begin
                vec_hi_d = mem_rdata;
                state_d  = S_JUMP;
            end
            S_JUMP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Moore output decode; only pc_next in JUMP sees mem_rdata directly.
    always_comb begin
        fetch_stall         = (state_q != S_IDLE);
        busy                = (state_q != S_IDLE);
        flush_decode        = 1'b0;
        mem_push            = 1'b0;
        mem_wdata           = '0;
        mem_read            = 1'b0;
        mem_raddr           = '0;
        pc_write            = 1'b0;
        pc_next             = '0;
        pc_choose_interrupt = 1'b0;
        case (state_q)
            S_FLUSH:   flush_decode = 1'b1;
            S_PUSH_HI: begin
                mem_push  = 1'b1;
                mem_wdata = pc_save_q[31:16];
            end
            S_PUSH_LO: begin
                mem_push  = 1'b1;
                mem_wdata = pc_save_q[15:0];
            end
`ifdef INT_SAVE_FLAGS_EN
            S_PUSH_FLG: begin
                mem_push  = 1'b1;
                mem_wdata = WORD_W'(flg_save_q);
            end
`endif
            S_RD_HI: begin
                mem_read  = 1'b1;
                mem_raddr = VEC_ADDR;
            end
            S_RD_LO: begin
                mem_read  = 1'b1;
                mem_raddr = VEC_ADDR_LO;
            end
            S_JUMP: begin
                pc_write            = 1'b1;
                pc_choose_interrupt = 1'b1;
                pc_next             = {vec_hi_q, mem_rdata};
            end
            default: ;
        endcase
    end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Multi-cycle controller that services the external interrupt for the 5-stage RISC pipeline. It waits for a safe instruction boundary, then sequences the following steps through the shared data memory port:

- flush the decode register,
- push the resume PC (two 16-bit words) and, optionally, the flag register onto the stack,
- fetch the 32-bit handler address from the vector location,
- redirect the PC.

It sits beside the decode-stage control unit. Fetch is held stalled for the whole sequence.

## Interface
Parameters:
- VEC_ADDR, 32'd0: memory address of the vector high word; the low word is at VEC_ADDR+1.
- FLAG_W, 4: flag register width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- interrupt_signal  in  1  external request; each rising edge is one request.
- boundary_ok  in  1  decode holds the first word of an instruction, and no taken jump or LDM immediate is in flight.
- pc_resume  in  32  PC of the instruction currently in decode.
- flags_in  in  FLAG_W  current flag register.
- mem_rdata  in  16  data memory read data, valid one cycle after mem_read.
- fetch_stall  out  1  freeze PC and the fetch/decode register.
- flush_decode  out  1  clear the decode/execute control fields.
- mem_push  out  1  push mem_wdata; the stack pointer update is external.
- mem_wdata  out  16  word to push.
- mem_read  out  1  read at mem_raddr.
- mem_raddr  out  32  vector read address.
- pc_write  out  1  load pc_next into PC.
- pc_next  out  32  handler address.
- pc_choose_interrupt  out  1  PC mux selects pc_next.
- busy  out  1  sequence in progress (any state except IDLE).
- int_pending  out  1  request latched, not yet started.

## Operation
Edge detect and pending:
- interrupt_signal is registered, and a rise sets `pending`. A rise while `pending` is already set is absorbed.
- A rise during a sequence sets `pending` and is serviced after return to IDLE.

States, in order: IDLE, FLUSH, PUSH_HI, PUSH_LO, PUSH_FLG (macro only), RD_HI, RD_LO, JUMP.
- IDLE: if (pending or rise) and boundary_ok, go to FLUSH and clear pending. Otherwise stay; a rise sets pending.
- FLUSH: flush_decode=1, fetch_stall=1. Capture pc_resume into pc_save and flags_in into flg_save.
- PUSH_HI: mem_push=1, mem_wdata=pc_save[31:16].
- PUSH_LO: mem_push=1, mem_wdata=pc_save[15:0].
- PUSH_FLG: mem_push=1, mem_wdata={zeros, flg_save}.
- RD_HI: mem_read=1, mem_raddr=VEC_ADDR.
- RD_LO: capture mem_rdata into vec_hi. mem_read=1, mem_raddr=VEC_ADDR+1.
- JUMP: pc_write=1, pc_choose_interrupt=1, pc_next={vec_hi, mem_rdata}. Then go to IDLE.

Output rules:
- fetch_stall=1 in every state from FLUSH through JUMP.
- All outputs are Moore (registered state decode), except pc_next in JUMP, which passes mem_rdata through combinationally.
- mem_push and mem_read are never asserted in the same cycle.
- Inactive outputs are 0; mem_wdata and mem_raddr are 0 outside their states.

## Timing
- Reset: state=IDLE. pending, edge register, pc_save, flg_save and vec_hi are cleared. Every output is 0.
- Reset mid-sequence aborts on that edge with no further push or read; any in-flight request is lost.
- Latency when boundary_ok=1 at the rise cycle:
  - rise sampled at edge N puts FLUSH at cycle N+1;
  - JUMP falls at N+6 without the macro, N+7 with it;
  - fetch at the vector address starts at N+7 / N+8.
- boundary_ok low holds IDLE indefinitely, with int_pending=1. No stall is asserted while waiting.
- pc_resume is sampled only in FLUSH; later changes are ignored.
- Address arithmetic: VEC_ADDR+1 is 32-bit modulo; VEC_ADDR=32'hFFFFFFFF wraps to 0.

## Configuration
- INT_SAVE_FLAGS_EN defined: PUSH_FLG is present and the sequence is 7 cycles. Three words are pushed: PC_hi, PC_lo, then flags.
- Undefined: PUSH_FLG and flg_save are removed, PUSH_LO goes directly to RD_HI, the sequence is 6 cycles, and flags_in is unused.

## Structure
- Package int_seq_pkg: the state enum (int_state_t), PC_W=32, WORD_W=16, and the PUSH_WORDS constant (2 or 3, chosen by the macro).
- One sub-module, int_req_latch: the edge detector plus pending flag, with a clear input driven by the IDLE→FLUSH transition.
- The FSM and capture registers stay in the top module.

## Test plan
- Single pulse, boundary_ok=1, pc_resume=32'h0001_0040, VEC words 16'h0000/16'h0200 → pushes 0001 then 0040, reads VEC then VEC+1, pc_write with pc_next=32'h0000_0200 at N+6; fetch_stall held for cycles N+1..N+6.
- boundary_ok=0 for 5 cycles after the rise → int_pending=1 and no stall; FLUSH occurs the cycle after boundary_ok rises.
- Second rise during PUSH_LO → first sequence completes; IDLE lasts one cycle; second FLUSH follows with the new pc_resume. Three rises during one sequence → only one extra service.
- Reset asserted in RD_HI → next cycle all outputs 0, state IDLE, int_pending=0; no pc_write ever occurs.
- With INT_SAVE_FLAGS_EN and flags_in=4'b1010 → third push is 16'h000A; pc_write occurs at N+7.
- interrupt_signal held high for 10 cycles → exactly one sequence.
